// File: rtl/cram_page_engine.sv
// cram_page_engine: CellularRAM controller; programs RCR/BCR after reset, then serves page-mode reads and async writes
module cram_page_engine #(
    parameter int          AW        = 22,
    parameter int          LW        = 3,
    parameter int          PAGE_BITS = 4,
    parameter int          RWC       = 5,
    parameter int          PC        = 2,
    parameter int          TB        = 3,
    parameter logic [15:0] RCR_D     = 16'h0090,
    parameter logic [15:0] BCR_D     = 16'h9D1F
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [AW-1:0] DIN_Address,
    input  logic [LW-1:0] DIN_Length,
    input  logic          DIN_Write,
    input  logic          Req_Valid,
    output logic          Req_Ready,
    input  logic [15:0]   DIN_Data,
    output logic          Data_Take,
    output logic [15:0]   DOUT_CPU,
    output logic          Data_Valid,
    output logic          Done,
    output logic          Config_Done,
    output logic [AW:0]   DOUT_ADDR,
    output logic          CRAM_CE_n,
    output logic          CRAM_OE_n,
    output logic          CRAM_WE_n,
    inout  wire  [15:0]   DIO_CRAM
);
    typedef enum logic [2:0] {CFG_SETUP, CFG_ACCESS, IDLE, RD_FIRST, RD_PAGE, WR_SETUP, WR_ACCESS} state_t;
    state_t state, state_next;
    logic [TB-1:0] timer;
    logic [2:0]    cfg_idx;
    logic [LW:0]   count;
    logic [15:0]   wdata, cfg_data;
    logic [AW:0]   addr_inc;
    logic          last, count_last, reading;
    always_comb begin
        last       = timer == TB'(1);
        count_last = count == (LW+1)'(1);
        addr_inc   = {DOUT_ADDR[AW:PAGE_BITS], DOUT_ADDR[PAGE_BITS-1:0] + PAGE_BITS'(1)};
        // config accesses 2/3 write the register select then RCR, 6/7 the same for BCR
        cfg_data   = cfg_idx[0] ? (cfg_idx[2] ? BCR_D : RCR_D) : {15'd0, cfg_idx[2]};
        reading    = state == RD_FIRST || (state == RD_PAGE && count != '0);
        Req_Ready  = state == IDLE;
        Data_Take  = state == WR_SETUP;
        CRAM_CE_n  = !(reading || state == CFG_ACCESS || state == WR_ACCESS);
        CRAM_OE_n  = !(reading || (state == CFG_ACCESS && !cfg_idx[1]));
        CRAM_WE_n  = !(state == WR_ACCESS || (state == CFG_ACCESS && cfg_idx[1]));
        state_next = state;
        case (state)
            CFG_SETUP:  state_next = CFG_ACCESS;
            CFG_ACCESS: if (last) state_next = cfg_idx == 3'd7 ? IDLE : CFG_SETUP;
            IDLE:       if (Req_Valid && DIN_Length != '0) state_next = DIN_Write ? WR_SETUP : RD_FIRST;
            RD_FIRST:   if (last) state_next = RD_PAGE;
            RD_PAGE:    if (count == '0) state_next = IDLE;
            WR_SETUP:   state_next = WR_ACCESS;
            WR_ACCESS:  if (last) state_next = count_last ? IDLE : WR_SETUP;
            default:    state_next = IDLE;
        endcase
    end
    assign DIO_CRAM = CRAM_WE_n ? 16'hzzzz : wdata;
    always_ff @(posedge Clock)
        if (Reset) state <= CFG_SETUP;
        else state <= state_next;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            timer       <= '0;
            cfg_idx     <= '0;
            count       <= '0;
            wdata       <= '0;
            DOUT_CPU    <= '0;
            DOUT_ADDR   <= '0;
            Data_Valid  <= 1'b0;
            Done        <= 1'b0;
            Config_Done <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Done       <= 1'b0;
            timer      <= timer - TB'(1);
            case (state)
                CFG_SETUP: begin
                    DOUT_ADDR <= '1;
                    wdata     <= cfg_data;
                    timer     <= TB'(RWC);
                end
                CFG_ACCESS:
                    if (last) begin
                        if (cfg_idx == 3'd7) Config_Done <= 1'b1;
                        else cfg_idx <= cfg_idx + 3'd1;
                    end
                IDLE:
                    if (Req_Valid) begin
                        DOUT_ADDR <= {DIN_Address, 1'b0};
                        count     <= {DIN_Length, 1'b0};
                        timer     <= TB'(RWC);
                        Done      <= DIN_Length == '0;
                    end
                RD_FIRST, RD_PAGE:
                    if (last && count != '0) begin
                        DOUT_CPU   <= DIO_CRAM;
                        Data_Valid <= 1'b1;
                        DOUT_ADDR  <= addr_inc;
                        count      <= count - (LW+1)'(1);
                        Done       <= count_last;
                        timer      <= TB'(PC);
                    end
                WR_SETUP: begin
                    wdata <= DIN_Data;
                    timer <= TB'(RWC);
                end
                WR_ACCESS:
                    if (last) begin
                        DOUT_ADDR <= addr_inc;
                        count     <= count - (LW+1)'(1);
                        Done      <= count_last;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cram_page_engine.sv
// tb_cram_page_engine: directed checks of config sequence, page reads, writes, null request and mid-access reset
module tb_cram_page_engine;
    logic        Clock, Reset, DIN_Write, Req_Valid, Req_Ready, Data_Take, Data_Valid, Done, Config_Done;
    logic        CRAM_CE_n, CRAM_OE_n, CRAM_WE_n;
    logic [21:0] DIN_Address;
    logic [2:0]  DIN_Length;
    logic [15:0] DIN_Data, DOUT_CPU;
    logic [22:0] DOUT_ADDR;
    wire  [15:0] dio;
    int n_chk = 0, n_pass = 0;
    int dv_c[$], dv_d[$], ac_a[$], wr_a[$], wr_d[$], wr_n[$], tk_c[$], cw[$];
    int done_c, rdy_c, ce_low, cfg_at, n_acc, bad_addr;

    cram_page_engine dut (
        .Clock(Clock), .Reset(Reset), .DIN_Address(DIN_Address), .DIN_Length(DIN_Length),
        .DIN_Write(DIN_Write), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .DIN_Data(DIN_Data),
        .Data_Take(Data_Take), .DOUT_CPU(DOUT_CPU), .Data_Valid(Data_Valid), .Done(Done),
        .Config_Done(Config_Done), .DOUT_ADDR(DOUT_ADDR), .CRAM_CE_n(CRAM_CE_n),
        .CRAM_OE_n(CRAM_OE_n), .CRAM_WE_n(CRAM_WE_n), .DIO_CRAM(dio)
    );

    // memory model: each half-word reads back as C000 ^ address
    assign dio = (!CRAM_OE_n && CRAM_WE_n) ? (16'hC000 ^ DOUT_ADDR[15:0]) : 16'hzzzz;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    always @(negedge Clock) if (!Reset) check("oe_we_overlap", 32'(CRAM_OE_n | CRAM_WE_n), 1);

    task automatic cfg_run();
        logic pce = 1'b1, pwe = 1'b1;
        cfg_at = -1; n_acc = 0; bad_addr = 0; cw.delete();
        for (int c = 0; c < 60; c++) begin
            if (Config_Done && cfg_at < 0) cfg_at = c;
            if (!CRAM_CE_n && pce) n_acc++;
            if (!CRAM_CE_n && DOUT_ADDR != 23'h7FFFFF) bad_addr++;
            if (!CRAM_WE_n && pwe) cw.push_back(int'(dio));
            pce = CRAM_CE_n; pwe = CRAM_WE_n;
            step();
        end
    endtask

    task automatic run(input logic [21:0] a, input logic [2:0] l, input logic w, input logic [15:0] d0, input logic [15:0] d1);
        logic pwe = 1'b1;
        int nd = 0, wl = 0;
        dv_c.delete(); dv_d.delete(); ac_a.delete(); wr_a.delete(); wr_d.delete(); wr_n.delete(); tk_c.delete();
        done_c = -1; rdy_c = -1; ce_low = 0;
        DIN_Address = a; DIN_Length = l; DIN_Write = w; Req_Valid = 1'b1;
        step();
        Req_Valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (Data_Valid) begin dv_c.push_back(c); dv_d.push_back(int'(DOUT_CPU)); end
            if (!CRAM_OE_n && (c == 0 || Data_Valid)) ac_a.push_back(int'(DOUT_ADDR));
            if (!CRAM_WE_n && pwe) begin wr_a.push_back(int'(DOUT_ADDR)); wr_d.push_back(int'(dio)); wl = 0; end
            if (!CRAM_WE_n) wl++;
            if (CRAM_WE_n && !pwe) wr_n.push_back(wl);
            if (Data_Take) begin tk_c.push_back(c); DIN_Data = nd == 0 ? d0 : d1; nd++; end
            if (Done && done_c < 0) done_c = c;
            if (Req_Ready && rdy_c < 0) rdy_c = c;
            if (!CRAM_CE_n) ce_low++;
            pwe = CRAM_WE_n;
            step();
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return q.size() > i ? q[i] : -1;
    endfunction

    initial begin
        Reset = 1'b1; Req_Valid = 1'b0; DIN_Address = '0; DIN_Length = '0; DIN_Write = 1'b0; DIN_Data = '0;
        repeat (3) step();
        check("rst_ready", 32'(Req_Ready), 0);
        check("rst_strobes", {29'd0, CRAM_CE_n, CRAM_OE_n, CRAM_WE_n}, 7);
        check("rst_flags", {28'd0, Config_Done, Data_Valid, Done, Data_Take}, 0);
        check("rst_dout", 32'(DOUT_CPU), 0);
        check("rst_addr", 32'(DOUT_ADDR), 0);
        Reset = 1'b0;
        cfg_run();
        check("cfg_done_cycle", cfg_at, 48);
        check("cfg_accesses", n_acc, 8);
        check("cfg_addr", bad_addr, 0);
        check("cfg_nwrites", cw.size(), 4);
        check("cfg_w0", at(cw, 0), 32'h0000);
        check("cfg_w1", at(cw, 1), 32'h0090);
        check("cfg_w2", at(cw, 2), 32'h0001);
        check("cfg_w3", at(cw, 3), 32'h9D1F);
        check("cfg_ready", 32'(Req_Ready), 1);

        run(22'h000005, 3'd2, 1'b0, '0, '0);
        check("rd_n", dv_c.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rd_dv_cycle", at(dv_c, i), 5 + 2 * i);
            check("rd_addr", at(ac_a, i), 32'h0A + i);
            check("rd_data", at(dv_d, i), 32'hC00A + i);
        end
        check("rd_done", done_c, 11);
        check("rd_ready", rdy_c, 12);
        check("rd_ce_low", ce_low, 11);

        run(22'h000007, 3'd2, 1'b0, '0, '0);
        check("wrap_a0", at(ac_a, 0), 32'h0E);
        check("wrap_a1", at(ac_a, 1), 32'h0F);
        check("wrap_a2", at(ac_a, 2), 32'h00);
        check("wrap_a3", at(ac_a, 3), 32'h01);
        check("wrap_d2", at(dv_d, 2), 32'hC000);

        run(22'h000100, 3'd1, 1'b1, 16'h1234, 16'hABCD);
        check("wr_take0", at(tk_c, 0), 0);
        check("wr_take1", at(tk_c, 1), 6);
        check("wr_a0", at(wr_a, 0), 32'h200);
        check("wr_a1", at(wr_a, 1), 32'h201);
        check("wr_d0", at(wr_d, 0), 32'h1234);
        check("wr_d1", at(wr_d, 1), 32'hABCD);
        check("wr_len0", at(wr_n, 0), 5);
        check("wr_len1", at(wr_n, 1), 5);
        check("wr_done", done_c, 12);
        check("wr_ready", rdy_c, 12);
        check("wr_no_read", dv_c.size(), 0);

        run(22'h000033, 3'd0, 1'b0, '0, '0);
        check("nul_done", done_c, 0);
        check("nul_ce", ce_low, 0);
        check("nul_dv", dv_c.size(), 0);

        DIN_Address = 22'h000005; DIN_Length = 3'd2; DIN_Write = 1'b0; Req_Valid = 1'b1;
        step();
        Req_Valid = 1'b0;
        check("mid_ce_low", 32'(CRAM_CE_n), 0);
        step(); step();
        Reset = 1'b1;
        step();
        check("mrst_strobes", {29'd0, CRAM_CE_n, CRAM_OE_n, CRAM_WE_n}, 7);
        check("mrst_ready", 32'(Req_Ready), 0);
        check("mrst_flags", {28'd0, Config_Done, Data_Valid, Done, Data_Take}, 0);
        check("mrst_addr", 32'(DOUT_ADDR), 0);
        Reset = 1'b0;
        cfg_run();
        check("mrst_cfg_cycle", cfg_at, 48);
        check("mrst_cfg_acc", n_acc, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cram_page_engine.md
# cram_page_engine

Parametrised CellularRAM access engine combining controller and datapath in one block. Sits between the CPU bus and the external PSRAM. After reset it programs RCR and BCR through the software-access sequence. It then serves multi-word requests: reads use asynchronous page mode, and writes are single asynchronous write cycles. Length, page size, access timing and configuration values are generic.

## Interface
- AW, 22: CPU word-address width; CRAM half-word address is AW+1 bits.
- LW, 3: request length field width, in 16-bit-pair words.
- PAGE_BITS, 4: log2 of half-words per page; address increments wrap inside this field.
- RWC, 5: cycles per random read/write access (≥1, ≥85 ns).
- PC, 2: cycles per intra-page read access (≥1, ≥25 ns).
- TB, 3: timer width; 2^TB > max(RWC, PC).
- RCR_D, 16'h0090: RCR value (default | page-mode enable).
- BCR_D, 16'h9D1F: BCR value.

Ports:
- Clock  in  1  single clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- DIN_Address  in  AW  request word address.
- DIN_Length  in  LW  request length in words; 0 = null request.
- DIN_Write  in  1  1 = write request, 0 = read request.
- Req_Valid  in  1  request present; must be held until accepted.
- Req_Ready  out  1  engine idle and configured; a request is accepted on an edge where Req_Valid & Req_Ready.
- DIN_Data  in  16  write half-word; sampled on edge ending a Data_Take cycle.
- Data_Take  out  1  write data consumed this cycle.
- DOUT_CPU  out  16  registered read half-word.
- Data_Valid  out  1  one-cycle strobe; DOUT_CPU holds new half-word.
- Done  out  1  one-cycle strobe; request complete.
- Config_Done  out  1  RCR/BCR programmed.
- DOUT_ADDR  out  AW+1  CRAM half-word address.
- CRAM_CE_n, CRAM_OE_n, CRAM_WE_n  out  1 each  active-low strobes.
- DIO_CRAM  inout  16  CRAM data bus; driven only during write cycles.

## Operation
- Reset (any cycle, including mid-access) returns all state to the following values, then restarts the config sequence:
  - Req_Ready=0, Config_Done=0, Data_Valid=0, Done=0, Data_Take=0.
  - DOUT_CPU=0, DOUT_ADDR=0.
  - CE_n=OE_n=WE_n=1, DIO_CRAM=Z.
- States:
  - CFG_SETUP and CFG_ACCESS: config sequence.
  - IDLE: waiting for a request.
  - RD_FIRST and RD_PAGE: read accesses.
  - WR_SETUP and WR_ACCESS: write accesses.
- Access rules:
  - Every access is preceded by at least one cycle with CE_n=1.
  - The access timer loads RWC (or PC) on entry and decrements each cycle. The access ends in the cycle where the timer equals 1.
- Config sequence: 8 accesses, each 1 setup cycle plus RWC access cycles, all at address all-ones:
  - For RCR: read, read, write 16'h0000, write RCR_D.
  - Then for BCR: read, read, write 16'h0001, write BCR_D.
  - Config reads discard their data; no Data_Valid is generated.
  - At the end: Config_Done=1 (held until Reset), then IDLE.
- IDLE: Req_Ready=1 and CE_n=1.
  - On accept: address register ← {DIN_Address,0} and half-word count ← 2·DIN_Length.
  - Length 0: Done pulses in the next cycle with no CRAM activity; engine stays in IDLE.
- Read path:
  - RD_FIRST: CE_n=OE_n=0, RWC cycles.
  - RD_PAGE: PC cycles per subsequent half-word; CE_n and OE_n stay low throughout the burst.
  - In each access's final cycle, DIO_CRAM is registered into DOUT_CPU. Data_Valid=1 the following cycle; at the same time the address increments (low PAGE_BITS bits +1 modulo 2^PAGE_BITS, upper bits unchanged) and the count decrements.
  - Done accompanies the final Data_Valid; the engine then returns to IDLE with CE_n=1.
- Write path, per half-word:
  - WR_SETUP (1 cycle): CE_n=1, Data_Take=1; DIN_Data latched.
  - WR_ACCESS (RWC cycles): CE_n=WE_n=0, OE_n=1, DIO_CRAM driven from the latch.
  - After each write, the address increments with the same page wrap and the count decrements.
  - Done pulses in the cycle after the last WR_ACCESS; the engine is in IDLE in that cycle.
- OE_n and WE_n are never low simultaneously. DIO_CRAM is high-Z whenever WE_n=1.
- Req_Valid while Req_Ready=0 is ignored.

## Timing
Edge E0 = accepting edge. Cycle k is the cycle after edge Ek.
- Read of N half-words (N=2L):
  - CE_n/OE_n fall in cycle 0.
  - Data_Valid in cycles RWC, RWC+PC, …, RWC+(N−1)·PC; Done coincides with the last.
  - Req_Ready=1 again in cycle RWC+(N−1)·PC+1.
- Write of N half-words:
  - Data_Take in cycles 0, RWC+1, …; each half-word occupies RWC+1 cycles.
  - Done and Req_Ready in cycle N·(RWC+1).
- Config_Done rises in cycle 8·(RWC+1) after the first cycle with Reset low.

## Test plan
- Reset release, defaults → CE_n high at all times outside accesses; 8 accesses at DOUT_ADDR=7FFFFF; write data 0000, 0090, 0001, 9D1F; Config_Done at cycle 48.
- Read, address 22'h000005, length 2 → DOUT_ADDR sequence 00000A, 00000B, 00000C, 00000D; Data_Valid at offsets 5, 7, 9, 11; Done at 11.
- Read, address 22'h000007, length 2 → DOUT_ADDR sequence 00000E, 00000F, 000000, 000001 (page wrap, upper bits kept).
- Write, address 22'h000100, length 1, DIN_Data 1234 then ABCD → two write pulses of 5 cycles each at 000200 and 000201, with matching bus data; Done at cycle 12.
- Length 0 request → Done one cycle later; CE_n stays 1.
- Reset asserted in the 3rd cycle of a read → next cycle all strobes high, bus Z, Req_Ready=0; config sequence restarts.
